mem_access_ctrl: RTL and testbench

//  MEM-stage data-memory access controller of the 32-bit MIPS pipeline. It sits between the EX/MEM

---
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: runs loads/stores over a req/ack bus,
// stalls the pipeline per access, steers byte lanes, extends load data, flags misalignment and timeout.
module mem_access_ctrl #(
    parameter int unsigned S           = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_valid,
    input  logic           ex_MemRead,
    input  logic           ex_MemWrite,
    input  logic [1:0]     ex_Size,
    input  logic           ex_Unsigned,
    input  logic [S-1:0]   ex_Addr,
    input  logic [S-1:0]   ex_WriteData,
    output logic           mem_stall,
    output logic [S-1:0]   mem_ReadData,
    output logic           mem_ReadValid,
    output logic           mem_AlignErr,
    output logic           mem_BusErr,
    output logic           dm_req,
    output logic           dm_we,
    output logic [S-3:0]   dm_addr,
    output logic [3:0]     dm_be,
    output logic [S-1:0]   dm_wdata,
    input  logic           dm_ack,
    input  logic [S-1:0]   dm_rdata
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    ld_off_q;
    logic [1:0]    ld_size_q;
    logic          ld_uns_q;

    logic          access;
    logic          misalign;
    logic          timeout_hit;
    logic [3:0]    st_be;
    logic [S-1:0]  st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [S-1:0]  ld_ext;

    assign access      = ex_valid & (ex_MemRead | ex_MemWrite);
    assign misalign    = ((ex_Size == 2'b01) & ex_Addr[0]) |
                         (ex_Size[1] & (ex_Addr[1:0] != 2'b00));
    assign timeout_hit = (cnt_q + CW'(1)) == CW'(TIMEOUT_CYC);

    // Little-endian store lane steering; reserved size behaves as word
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_WriteData;
        case (ex_Size)
            2'b00: begin
                st_be    = 4'b0001 << ex_Addr[1:0];
                st_wdata = {4{ex_WriteData[7:0]}};
            end
            2'b01: begin
                st_be    = ex_Addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension from the attributes latched at accept
    always_comb begin
        ld_byte = dm_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = dm_rdata[{ld_off_q[1], 4'b0000} +: 16];
        ld_ext  = dm_rdata;
        case (ld_size_q)
            2'b00:   ld_ext = ld_uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = ld_uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misalign) begin
                    state_d   = REQ;
                    mem_stall = 1'b1;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dm_ack || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs, result data, status pulses and timeout counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_be         <= '0;
            dm_wdata      <= '0;
            mem_ReadData  <= '0;
            mem_ReadValid <= 1'b0;
            mem_AlignErr  <= 1'b0;
            mem_BusErr    <= 1'b0;
            cnt_q         <= '0;
            ld_off_q      <= '0;
            ld_size_q     <= '0;
            ld_uns_q      <= 1'b0;
        end else begin
            mem_ReadValid <= 1'b0;
            mem_AlignErr  <= 1'b0;
            mem_BusErr    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access && misalign) begin
                        mem_AlignErr <= 1'b1;
                    end else if (access) begin
                        dm_req    <= 1'b1;
                        dm_we     <= ex_MemWrite;
                        dm_addr   <= ex_Addr[S-1:2];
                        dm_be     <= ex_MemWrite ? st_be : 4'b1111;
                        dm_wdata  <= ex_MemWrite ? st_wdata : '0;
                        ld_off_q  <= ex_Addr[1:0];
                        ld_size_q <= ex_Size;
                        ld_uns_q  <= ex_Unsigned;
                        cnt_q     <= '0;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            mem_ReadData  <= ld_ext;
                            mem_ReadValid <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (timeout_hit) begin
                            dm_req     <= 1'b0;
                            mem_BusErr <= 1'b1;
                            if (!dm_we) mem_ReadData <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, extension,
// misalignment, bus timeout and reset in the middle of an access.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_MemRead, ex_MemWrite, ex_Unsigned;
    logic [1:0]  ex_Size;
    logic [31:0] ex_Addr, ex_WriteData;
    logic        mem_stall, mem_ReadValid, mem_AlignErr, mem_BusErr;
    logic [31:0] mem_ReadData;
    logic        dm_req, dm_we, dm_ack;
    logic [29:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.S(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Size(ex_Size), .ex_Unsigned(ex_Unsigned), .ex_Addr(ex_Addr),
        .ex_WriteData(ex_WriteData),
        .mem_stall(mem_stall), .mem_ReadData(mem_ReadData), .mem_ReadValid(mem_ReadValid),
        .mem_AlignErr(mem_AlignErr), .mem_BusErr(mem_BusErr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        ex_valid     = 1'b1;
        ex_MemRead   = rd;
        ex_MemWrite  = wr;
        ex_Size      = sz;
        ex_Unsigned  = uns;
        ex_Addr      = a;
        ex_WriteData = wd;
        #1;
    endtask

    // From the REQ cycle: wait `dly` cycles, ack with `rd`, and land in DONE
    task automatic ack_after(input int dly, input logic [31:0] rd);
        for (int i = 0; i < dly; i++) step();
        dm_ack   = 1'b1;
        dm_rdata = rd;
        step();
        dm_ack   = 1'b0;
        ex_valid = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b0; ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
        ex_Size = 2'b10; ex_Unsigned = 1'b0; ex_Addr = '0; ex_WriteData = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        step(); step();
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_rdata", mem_ReadData, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_be", 32'(dm_be), 32'd0);
        reset = 1'b1;
        step();

        // lw 0x100, ack in the second REQ cycle: three stall cycles
        drive(1, 0, 2'b10, 0, 32'h100, 32'h0);
        chk("lw_stall_t0", 32'(mem_stall), 32'd1);
        step();
        chk("lw_req", 32'(dm_req), 32'd1);
        chk("lw_addr", 32'(dm_addr), 32'h40);
        chk("lw_be", 32'(dm_be), 32'hF);
        chk("lw_we", 32'(dm_we), 32'd0);
        chk("lw_stall_t1", 32'(mem_stall), 32'd1);
        step();
        chk("lw_stall_t2", 32'(mem_stall), 32'd1);
        ack_after(0, 32'hDEADBEEF);
        chk("lw_done_stall", 32'(mem_stall), 32'd0);
        chk("lw_done_req", 32'(dm_req), 32'd0);
        chk("lw_valid", 32'(mem_ReadValid), 32'd1);
        chk("lw_data", mem_ReadData, 32'hDEADBEEF);
        step();
        chk("lw_valid_drop", 32'(mem_ReadValid), 32'd0);
        chk("lw_data_hold", mem_ReadData, 32'hDEADBEEF);

        // lb / lbu at 0x103
        drive(1, 0, 2'b00, 0, 32'h103, 32'h0);
        step();
        ack_after(0, 32'h80000000);
        chk("lb_data", mem_ReadData, 32'hFFFFFF80);
        step();
        drive(1, 0, 2'b00, 1, 32'h103, 32'h0);
        step();
        ack_after(0, 32'h80000000);
        chk("lbu_data", mem_ReadData, 32'h00000080);
        step();

        // lh upper half, then lhu lower half
        drive(1, 0, 2'b01, 0, 32'h102, 32'h0);
        step();
        ack_after(1, 32'h80011234);
        chk("lh_data", mem_ReadData, 32'hFFFF8001);
        step();
        drive(1, 0, 2'b01, 1, 32'h100, 32'h0);
        step();
        ack_after(0, 32'h0000F00D);
        chk("lhu_data", mem_ReadData, 32'h0000F00D);
        step();

        // sh 0x202: upper lanes, replicated halfword, no read result
        drive(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD);
        step();
        chk("sh_we", 32'(dm_we), 32'd1);
        chk("sh_addr", 32'(dm_addr), 32'h80);
        chk("sh_be", 32'(dm_be), 32'hC);
        chk("sh_wdata", dm_wdata, 32'hABCDABCD);
        ack_after(0, 32'h0);
        chk("sh_valid", 32'(mem_ReadValid), 32'd0);
        chk("sh_data_hold", mem_ReadData, 32'h0000F00D);
        step();

        // sb 0x201
        drive(0, 1, 2'b00, 0, 32'h201, 32'h00000012);
        step();
        chk("sb_be", 32'(dm_be), 32'h2);
        chk("sb_wdata", dm_wdata, 32'h12121212);
        ack_after(0, 32'h0);
        step();

        // Misaligned lw 0x101: no bus cycle, AlignErr next cycle
        drive(1, 0, 2'b10, 0, 32'h101, 32'h0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("mis_alignerr", 32'(mem_AlignErr), 32'd1);
        chk("mis_req", 32'(dm_req), 32'd0);
        chk("mis_stall2", 32'(mem_stall), 32'd0);
        step();
        chk("mis_alignerr_drop", 32'(mem_AlignErr), 32'd0);

        // sw with no ack: dm_req held 16 cycles then BusErr
        drive(0, 1, 2'b10, 0, 32'h300, 32'hCAFEF00D);
        step();
        n = 0;
        while (dm_req && n < 40) begin
            n++;
            step();
        end
        ex_valid = 1'b0;
        #1;
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_buserr", 32'(mem_BusErr), 32'd1);
        chk("to_stall", 32'(mem_stall), 32'd0);
        chk("to_valid", 32'(mem_ReadValid), 32'd0);
        step();
        chk("to_buserr_drop", 32'(mem_BusErr), 32'd0);

        // Reset during second REQ cycle, then a stray ack
        drive(1, 0, 2'b10, 0, 32'h104, 32'h0);
        step();
        step();
        chk("rr_req_before", 32'(dm_req), 32'd1);
        reset = 1'b0;
        step();
        chk("rr_req", 32'(dm_req), 32'd0);
        chk("rr_valid", 32'(mem_ReadValid), 32'd0);
        chk("rr_data", mem_ReadData, 32'd0);
        reset    = 1'b1;
        ex_valid = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 32'h99999999;
        step();
        dm_ack = 1'b0;
        #1;
        chk("rr_stray_valid", 32'(mem_ReadValid), 32'd0);
        chk("rr_stray_req", 32'(dm_req), 32'd0);
        chk("rr_idle_stall", 32'(mem_stall), 32'd0);

        // Back-to-back lw: next instruction presented during DONE
        drive(1, 0, 2'b10, 0, 32'h108, 32'h0);
        step();
        ack_after(0, 32'h11223344);
        chk("bb1_data", mem_ReadData, 32'h11223344);
        drive(1, 0, 2'b10, 0, 32'h10C, 32'h0);
        chk("bb_done_stall", 32'(mem_stall), 32'd0);
        step();
        chk("bb2_stall_t0", 32'(mem_stall), 32'd1);
        step();
        chk("bb2_req", 32'(dm_req), 32'd1);
        chk("bb2_addr", 32'(dm_addr), 32'h43);
        ack_after(0, 32'h55667788);
        chk("bb2_valid", 32'(mem_ReadValid), 32'd1);
        chk("bb2_data", mem_ReadData, 32'h55667788);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
